// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline boundary register with a valid/ready handshake, a
//   one-entry skid buffer, bubble insertion and flush. One instance per
//   stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     defined   -> 32-bit saturating stall-cycle counter on perf_stall
//     undefined -> perf_stall tied to zero, no counter logic
//
// Ports
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       upstream holds a real instruction
//   in_ready   out  1       stage can accept this cycle (registered)
//   in_data    in   DATA_W  upstream data payload
//   in_ctrl    in   CTRL_W  upstream control payload
//   flush      in   1       kill all held contents
//   out_valid  out  1       out_data/out_ctrl hold a real instruction
//   out_ready  in   1       downstream consumes this cycle (0 = stall)
//   out_data   out  DATA_W  registered data payload
//   out_ctrl   out  CTRL_W  registered control payload, RST_CTRL on bubble
//   perf_stall out  32      stall-cycle count (feature macro only)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned          DATA_W   = 64,
    parameter int unsigned          CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]    RST_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       perf_stall
);

    localparam int unsigned PERF_W = 32;

    // Main slot: m_ctrl_q always carries RST_CTRL while m_v_q=0, so it can
    // drive out_ctrl directly without an output mux.
    logic              m_v_q,    m_v_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;

    // Skid slot: catches the one item accepted while the main slot stalls.
    logic              s_v_q,    s_v_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

    // Registered copy of !s_v so in_ready has no path from out_ready.
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic              drain;

    // Next-state for both slots.
    always_comb begin
        m_v_d    = m_v_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_v_d    = s_v_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;

        accept = in_valid & in_ready_q;
        drain  = m_v_q & out_ready;

        if (flush) begin
            // Flush wins over a same-cycle accept; data regs may keep stale values.
            m_v_d    = 1'b0;
            m_ctrl_d = RST_CTRL;
            s_v_d    = 1'b0;
        end else if (s_v_q) begin
            // in_ready is low here, so nothing can be accepted this cycle.
            if (drain) begin
                m_v_d    = 1'b1;
                m_data_d = s_data_q;
                m_ctrl_d = s_ctrl_q;
                s_v_d    = 1'b0;
            end
        end else if (accept) begin
            if (!m_v_q || drain) begin
                m_v_d    = 1'b1;
                m_data_d = in_data;
                m_ctrl_d = in_ctrl;
            end else begin
                s_v_d    = 1'b1;
                s_data_d = in_data;
                s_ctrl_d = in_ctrl;
            end
        end else if (drain) begin
            // Bubble: keep the data, squash control.
            m_v_d    = 1'b0;
            m_ctrl_d = RST_CTRL;
        end

        in_ready_d = ~s_v_d;
    end

    // Slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v_q      <= 1'b0;
            m_data_q   <= '0;
            m_ctrl_q   <= RST_CTRL;
            s_v_q      <= 1'b0;
            s_data_q   <= '0;
            s_ctrl_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_v_q      <= m_v_d;
            m_data_q   <= m_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_v_q      <= s_v_d;
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_v_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;

`ifdef PIPE_PERF_CNT_EN
    // Saturating count of cycles where a valid item is held back downstream.
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        if (m_v_q && !out_ready && !flush && (perf_stall_q != {PERF_W{1'b1}})) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_stall = perf_stall_q;
`else
    assign perf_stall = PERF_W'(0);
`endif

endmodule
